// File: rtl/riscv_lsu_pkg.sv
// Shared memory-command encodings, LSU state type and lane helpers for riscv_lsu.
package riscv_lsu_pkg;

    localparam logic MEM_FUNC_RD = 1'b0;
    localparam logic MEM_FUNC_WR = 1'b1;

    localparam logic [2:0] MASK_B    = 3'b000;
    localparam logic [2:0] MASK_H    = 3'b001;
    localparam logic [2:0] MASK_W    = 3'b010;
    localparam logic [2:0] MASK_BU   = 3'b100;
    localparam logic [2:0] MASK_HU   = 3'b101;
    localparam logic [2:0] MASK_NONE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } lsu_state_e;

    // Unknown size codes are rejected the same way as MASK_NONE.
    function automatic logic access_err(input logic [2:0] size, input logic [1:0] off);
        case (size)
            MASK_B, MASK_BU: access_err = 1'b0;
            MASK_H, MASK_HU: access_err = off[0];
            MASK_W:          access_err = |off;
            default:         access_err = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_we(input logic [2:0] size, input logic [1:0] off);
        case (size)
            MASK_B, MASK_BU: store_we = 4'b0001 << off;
            MASK_H, MASK_HU: store_we = 4'b0011 << off;
            default:         store_we = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_din(input logic [2:0] size, input logic [31:0] wdata);
        case (size)
            MASK_B, MASK_BU: store_din = {4{wdata[7:0]}};
            MASK_H, MASK_HU: store_din = {2{wdata[15:0]}};
            default:         store_din = wdata;
        endcase
    endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Picks the addressed byte/half out of a BRAM word and sign/zero-extends it.
module riscv_load_align
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (size)
            MASK_B:  data = {{24{lane_b[7]}}, lane_b};
            MASK_BU: data = {24'd0, lane_b};
            MASK_H:  data = {{16{lane_h[15]}}, lane_h};
            MASK_HU: data = {16'd0, lane_h};
            MASK_W:  data = word;
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one request at a time into a byte-enabled synchronous BRAM,
// returning an extended load value or a store acknowledgement.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic                  req_func_in,
    input  logic [2:0]            req_size_in,
    input  logic [31:0]           req_addr_in,
    input  logic [31:0]           req_wdata_in,
    output logic                  resp_valid_out,
    input  logic                  resp_ready_in,
    output logic [31:0]           resp_data_out,
    output logic                  resp_err_out,
    output logic                  bram_en_out,
    output logic [3:0]            bram_we_out,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [31:0]           bram_din_out,
    input  logic [31:0]           bram_dout_in
);

    lsu_state_e            state, state_next;
    logic                  rdy_q;
    logic                  func_q;
    logic [2:0]            size_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            cnt_q;
    logic [31:0]           data_q;
    logic                  err_q;
    logic [31:0]           load_val;
    logic                  accept;
    logic                  req_err;
    logic                  in_issue;
    logic                  is_store;
    logic                  unused_addr;

    // Upper address bits are dropped so accesses wrap modulo the BRAM size.
    assign unused_addr = ^req_addr_in[31:ADDR_WIDTH+2];

    assign accept   = req_valid_in & req_ready_out;
    assign req_err  = access_err(req_size_in, req_addr_in[1:0]);
    assign in_issue = (state == ISSUE);
    assign is_store = (func_q == MEM_FUNC_WR);

    riscv_load_align u_align (
        .word (bram_dout_in),
        .off  (off_q),
        .size (size_q),
        .data (load_val)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_err ? RESP : ISSUE;
            ISSUE:   state_next = is_store ? RESP : WAIT;
            WAIT:    if (cnt_q == 3'd0) state_next = RESP;
            RESP:    if (resp_ready_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rdy_q follows "next state is IDLE", so it stays low through reset and
    // rises one edge after reset release or after a response is taken.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= IDLE;
            rdy_q   <= 1'b0;
            func_q  <= MEM_FUNC_RD;
            size_q  <= MASK_NONE;
            off_q   <= 2'd0;
            waddr_q <= '0;
            wdata_q <= 32'd0;
            cnt_q   <= 3'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            rdy_q <= (state_next == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        func_q  <= req_func_in;
                        size_q  <= req_size_in;
                        off_q   <= req_addr_in[1:0];
                        waddr_q <= req_addr_in[ADDR_WIDTH+1:2];
                        wdata_q <= req_wdata_in;
                        data_q  <= 32'd0;
                        err_q   <= req_err;
                    end
                end
                ISSUE: cnt_q <= 3'(BRAM_LATENCY - 1);
                WAIT: begin
                    if (cnt_q == 3'd0) data_q <= load_val;
                    else               cnt_q  <= cnt_q - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_out  = rdy_q;
    assign resp_valid_out = (state == RESP);
    assign resp_data_out  = resp_valid_out ? data_q : 32'd0;
    assign resp_err_out   = resp_valid_out & err_q;

    assign bram_en_out   = in_issue;
    assign bram_we_out   = (in_issue && is_store) ? store_we(size_q, off_q) : 4'b0000;
    assign bram_addr_out = in_issue ? waddr_q : '0;
    assign bram_din_out  = (in_issue && is_store) ? store_din(size_q, wdata_q) : 32'd0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: byte-array reference memory, BRAM model with latency.
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    localparam int AW     = 12;
    localparam int LAT    = 2;
    localparam int NBYTES = 4 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_func = 1'b0;
    logic [2:0]    req_size = 3'd0;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_data;
    logic          resp_err;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_din;
    logic [31:0]   bram_dout;

    always #5 clk = ~clk;

    riscv_lsu #(.ADDR_WIDTH(AW), .BRAM_LATENCY(LAT)) dut (
        .clk_in(clk), .rst_in(rst),
        .req_valid_in(req_valid), .req_ready_out(req_ready),
        .req_func_in(req_func), .req_size_in(req_size),
        .req_addr_in(req_addr), .req_wdata_in(req_wdata),
        .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
        .resp_data_out(resp_data), .resp_err_out(resp_err),
        .bram_en_out(bram_en), .bram_we_out(bram_we),
        .bram_addr_out(bram_addr), .bram_din_out(bram_din),
        .bram_dout_in(bram_dout)
    );

    // Synchronous BRAM: data for an enable cycle appears LAT cycles later.
    logic [31:0] bram [0:(1<<AW)-1];
    logic [31:0] rd_pipe [0:LAT-1];
    always @(posedge clk) begin
        if (bram_en) begin
            rd_pipe[0] <= bram[bram_addr];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bram[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
        end
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_dout = rd_pipe[LAT-1];

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] refm [0:NBYTES-1];
    int         tests = 0;
    int         fails = 0;
    int         rr_mode = 1;
    int         en_pulses = 0;
    logic       iss_en;
    logic [3:0] iss_we;
    logic [31:0] iss_addr;
    logic [31:0] iss_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_data"},  resp_data, 32'd0);
        check({tag, "_err"},   32'(resp_err), 32'd0);
        check({tag, "_en"},    32'(bram_en), 32'd0);
        check({tag, "_we"},    32'(bram_we), 32'd0);
        check({tag, "_addr"},  32'(bram_addr), 32'd0);
        check({tag, "_din"},   bram_din, 32'd0);
    endtask

    // Reference: little-endian byte memory, wrap modulo BRAM size.
    task automatic model_req(input logic f, input logic [2:0] s, input logic [31:0] a,
                             input logic [31:0] w, output exp_t e);
        int ba, nb;
        bit sgn;
        longint v;
        ba = int'(a % NBYTES);
        e.data = 32'd0;
        e.err  = 1'b0;
        nb = 0;
        sgn = 0;
        case (s)
            MASK_B:  begin nb = 1; sgn = 1; end
            MASK_BU: nb = 1;
            MASK_H:  begin nb = 2; sgn = 1; end
            MASK_HU: nb = 2;
            MASK_W:  nb = 4;
            default: nb = 0;
        endcase
        if (nb == 0 || (ba % nb) != 0) begin
            e.err = 1'b1;
            return;
        end
        if (f == MEM_FUNC_WR) begin
            for (int i = 0; i < nb; i++) refm[ba+i] = 8'((w >> (8*i)) & 32'hFF);
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v += longint'(refm[ba+i]) << (8*i);
            if (sgn && v >= (64'd1 << (8*nb-1))) v = v - (64'sd1 << (8*nb));
            e.data = v[31:0];
        end
    endtask

    task automatic issue(input logic f, input logic [2:0] s, input logic [31:0] a,
                         input logic [31:0] w, input bit use_exp,
                         input logic [31:0] xdata, input logic xerr, output exp_t e);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles");
            e.data = 32'd0; e.err = 1'b0;
            return;
        end
        model_req(f, s, a, w, e);
        if (use_exp) begin e.data = xdata; e.err = xerr; end
        sb.push_back(e);
        req_valid = 1'b1; req_func = f; req_size = s; req_addr = a; req_wdata = w;
        @(negedge clk);
        req_valid = 1'b0;
        iss_en = bram_en; iss_we = bram_we; iss_addr = 32'(bram_addr); iss_din = bram_din;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (!resp_valid && cyc < 100) begin @(negedge clk); cyc++; end
    endtask

    // Directed transaction with latency check: error 1, store 2, load LAT+2.
    task automatic txn(input logic f, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] w, input bit use_exp,
                       input logic [31:0] xdata, input logic xerr);
        exp_t e;
        int cyc, lat;
        issue(f, s, a, w, use_exp, xdata, xerr, e);
        wait_resp(cyc);
        lat = e.err ? 1 : (f == MEM_FUNC_WR) ? 2 : LAT + 2;
        check("latency", 32'(cyc), 32'(lat));
        @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk); #1;
        resp_ready = (rr_mode == 0) ? ($urandom_range(0, 3) != 0) : (rr_mode == 1);
    end

    always @(negedge clk) begin
        exp_t e;
        if (resp_valid && resp_ready && !rst) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_resp: got data=%08h err=%0b expected no response", resp_data, resp_err);
            end else begin
                e = sb.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
        if (bram_en) en_pulses++;
    end

    initial begin
        exp_t e;
        int cyc, en_before;
        logic [2:0] okc [5] = '{MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU};
        logic [31:0] bexp [4] = '{32'hFFFFFFA5, 32'hFFFFFFF0, 32'h00000070, 32'hFFFFFF80};
        logic [31:0] buexp [4] = '{32'h000000A5, 32'h000000F0, 32'h00000070, 32'h00000080};

        for (int i = 0; i < (1 << AW); i++) begin
            bram[i] = $urandom;
            for (int b = 0; b < 4; b++) refm[4*i+b] = bram[i][8*b +: 8];
        end

        repeat (3) @(negedge clk);
        check_zero_outs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        txn(MEM_FUNC_WR, MASK_W, 32'h10, 32'hDEADBEEF, 1, 32'd0, 1'b0);
        txn(MEM_FUNC_RD, MASK_W, 32'h10, 32'd0, 1, 32'hDEADBEEF, 1'b0);
        issue(MEM_FUNC_WR, MASK_W, 32'h10, 32'hDEADBEEF, 1, 32'd0, 1'b0, e);
        check("sw_we", 32'(iss_we), 32'hF);
        check("sw_addr", iss_addr, 32'd4);
        check("sw_din", iss_din, 32'hDEADBEEF);
        wait_resp(cyc);
        @(negedge clk);

        txn(MEM_FUNC_WR, MASK_W, 32'h20, 32'h8070F0A5, 1, 32'd0, 1'b0);
        for (int o = 0; o < 4; o++) txn(MEM_FUNC_RD, MASK_B, 32'h20 + o, 32'd0, 1, bexp[o], 1'b0);
        for (int o = 0; o < 4; o++) txn(MEM_FUNC_RD, MASK_BU, 32'h20 + o, 32'd0, 1, buexp[o], 1'b0);

        issue(MEM_FUNC_WR, MASK_H, 32'h22, 32'h00001234, 1, 32'd0, 1'b0, e);
        check("sh_we", 32'(iss_we), 32'hC);
        check("sh_din", iss_din, 32'h12341234);
        wait_resp(cyc);
        @(negedge clk);
        txn(MEM_FUNC_RD, MASK_HU, 32'h22, 32'd0, 1, 32'h00001234, 1'b0);
        txn(MEM_FUNC_RD, MASK_H, 32'h20, 32'd0, 1, 32'hFFFFF0A5, 1'b0);

        en_before = en_pulses;
        txn(MEM_FUNC_RD, MASK_W, 32'h13, 32'd0, 1, 32'd0, 1'b1);
        txn(MEM_FUNC_WR, MASK_H, 32'h15, 32'hFFFF, 1, 32'd0, 1'b1);
        txn(MEM_FUNC_RD, MASK_NONE, 32'h20, 32'd0, 1, 32'd0, 1'b1);
        check("err_no_bram_en", 32'(en_pulses), 32'(en_before));
        txn(MEM_FUNC_RD, MASK_W, 32'h20, 32'd0, 0, 32'd0, 1'b0);

        rr_mode = 2;
        repeat (2) @(negedge clk);
        issue(MEM_FUNC_RD, MASK_W, 32'h20, 32'd0, 0, 32'd0, 1'b0, e);
        wait_resp(cyc);
        req_valid = 1'b1; req_func = MEM_FUNC_WR; req_size = MASK_W;
        req_addr = 32'h20; req_wdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_data", resp_data, e.data);
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rr_mode = 1;
        cyc = 0;
        while (resp_valid && cyc < 20) begin @(negedge clk); cyc++; end
        txn(MEM_FUNC_RD, MASK_W, 32'h20, 32'd0, 0, 32'd0, 1'b0);

        issue(MEM_FUNC_RD, MASK_W, 32'h10, 32'd0, 0, 32'd0, 1'b0, e);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outs("midrst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", 32'(req_ready), 32'd1);
        txn(MEM_FUNC_RD, MASK_W, 32'h10, 32'd0, 1, 32'hDEADBEEF, 1'b0);
        txn(MEM_FUNC_RD, MASK_W, 32'h10 | (32'h5 << (AW+2)), 32'd0, 1, 32'hDEADBEEF, 1'b0);

        rr_mode = 0;
        for (int n = 0; n < 400; n++) begin
            logic        f;
            logic [2:0]  s;
            logic [31:0] a;
            f = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : okc[$urandom_range(0, 4)];
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << (AW+2));
            issue(f, s, a, $urandom, 0, 32'd0, 1'b0, e);
        end

        rr_mode = 1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin @(negedge clk); cyc++; end
        check("drain_left", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
